regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: A (ALU/EX-MEM result) and B (load unit, including LDP pair loads). Round-robin arbitration, valid/ready handshakes, and a 2-state FSM that serialises pair writes. Produces a registered write address and data, plus a one-hot 32-bit write-select bus that feeds the register file's per-register enables. This bus is functionally decoder5x32 with enable=wr_en. Writes to X31 (XZR) are accepted but suppressed.

---
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between the ALU (A) and the load unit (B).
// Optional forwarding-hit outputs are enabled with the REGWR_FWD_EN macro.
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_pair,
  input  logic [ADDR_W-1:0] b_addr2,
  input  logic [DATA_W-1:0] b_data2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       wr_sel,
  output logic              busy
`ifdef REGWR_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_addr_a,
  input  logic [ADDR_W-1:0] fwd_addr_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b
`endif
);

  localparam logic [ADDR_W-1:0] XZR = '1;

  typedef enum logic {IDLE, PAIR2} state_t;

  state_t            state_reg, state_next;
  logic              prio_reg, prio_next;
  logic [ADDR_W-1:0] pair_addr_reg, pair_addr_next;
  logic [DATA_W-1:0] pair_data_reg, pair_data_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic [31:0]       wr_sel_reg, wr_sel_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      prio_reg      <= 1'b0;
      pair_addr_reg <= '0;
      pair_data_reg <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      wr_sel_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      prio_reg      <= prio_next;
      pair_addr_reg <= pair_addr_next;
      pair_data_reg <= pair_data_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      wr_sel_reg    <= wr_sel_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prio_next      = prio_reg;
    pair_addr_next = pair_addr_reg;
    pair_data_next = pair_data_reg;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    a_ready        = 1'b0;
    b_ready        = 1'b0;
    case (state_reg)
      IDLE: begin
        // prio=0 favours A under contention; an uncontended side always wins
        if (reset_n) begin
          a_ready = a_valid && (!b_valid || !prio_reg);
          b_ready = b_valid && (!a_valid || prio_reg);
        end
        if (a_ready) begin
          wr_en_next   = (a_addr != XZR);
          wr_addr_next = a_addr;
          wr_data_next = a_data;
          prio_next    = 1'b1;
        end else if (b_ready) begin
          wr_en_next   = (b_addr != XZR);
          wr_addr_next = b_addr;
          wr_data_next = b_data;
          prio_next    = 1'b0;
          if (b_pair) begin
            pair_addr_next = b_addr2;
            pair_data_next = b_data2;
            state_next     = PAIR2;
          end
        end
      end
      PAIR2: begin
        wr_en_next   = (pair_addr_reg != XZR);
        wr_addr_next = pair_addr_reg;
        wr_data_next = pair_data_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Select bus is decoded from the next-state values so it lands in the same register stage as wr_en/wr_addr.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sel
      assign wr_sel_next[gi] = wr_en_next && (wr_addr_next == ADDR_W'(gi));
    end
  endgenerate

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign wr_sel  = wr_sel_reg;
  assign busy    = (state_reg == PAIR2);

`ifdef REGWR_FWD_EN
  // wr_en is already low for XZR, so a hit can never report register 31.
  assign fwd_hit_a = wr_en_reg && (wr_addr_reg == fwd_addr_a);
  assign fwd_hit_b = wr_en_reg && (wr_addr_reg == fwd_addr_b);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              a_valid, a_ready;
  logic [4:0]        a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_ready;
  logic [4:0]        b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_pair;
  logic [4:0]        b_addr2;
  logic [DATA_W-1:0] b_data2;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       wr_sel;
  logic              busy;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .b_pair(b_pair), .b_addr2(b_addr2), .b_data2(b_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: writes still owed to the register file, one per cycle.
  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t             beat_q[$];
  logic              m_prio;
  logic              exp_en, exp_busy;
  logic [4:0]        exp_addr;
  logic [DATA_W-1:0] exp_data;

  function automatic void model_reset();
    beat_q.delete();
    m_prio   = 1'b0;
    exp_en   = 1'b0;
    exp_busy = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endfunction

  function automatic logic [31:0] onehot(input logic en, input logic [4:0] addr);
    logic [31:0] v;
    v = 32'd0;
    if (en) v[addr] = 1'b1;
    return v;
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, ".wr_en"},   wr_en,   exp_en);
    check({pfx, ".wr_addr"}, wr_addr, exp_addr);
    check({pfx, ".wr_data"}, wr_data, exp_data);
    check({pfx, ".wr_sel"},  wr_sel,  onehot(exp_en, exp_addr));
    check({pfx, ".busy"},    busy,    exp_busy);
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step(input logic av, input logic [4:0] aa, input logic [DATA_W-1:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [DATA_W-1:0] bd,
                      input logic bp, input logic [4:0] ba2, input logic [DATA_W-1:0] bd2,
                      output logic got_a, output logic got_b);
    logic  er_a, er_b, issue;
    beat_t bt;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    b_pair = bp; b_addr2 = ba2; b_data2 = bd2;
    #1;
    if (beat_q.size() > 0) begin
      er_a = 1'b0;
      er_b = 1'b0;
    end else begin
      er_a = av && (!bv || !m_prio);
      er_b = bv && (!av || m_prio);
    end
    check("a_ready", a_ready, er_a);
    check("b_ready", b_ready, er_b);
    got_a = er_a;
    got_b = er_b;
    issue = 1'b1;
    bt = '0;
    if (beat_q.size() > 0) begin
      bt = beat_q.pop_front();
    end else if (er_a) begin
      bt = '{addr: aa, data: ad};
      m_prio = 1'b1;
      $display("[TB] t=%0t grant A addr=%0d data=0x%0h", $time, aa, ad);
    end else if (er_b) begin
      bt = '{addr: ba, data: bd};
      m_prio = 1'b0;
      if (bp) beat_q.push_back('{addr: ba2, data: bd2});
      $display("[TB] t=%0t grant B addr=%0d data=0x%0h pair=%0d addr2=%0d data2=0x%0h",
               $time, ba, bd, bp, ba2, bd2);
    end else begin
      issue = 1'b0;
    end
    if (issue) begin
      exp_en   = (bt.addr != 5'd31);
      exp_addr = bt.addr;
      exp_data = bt.data;
    end else begin
      exp_en = 1'b0;
    end
    exp_busy = (beat_q.size() > 0);
    @(negedge clk);
    check_outputs("out");
  endtask

  task automatic idle_step();
    logic ga, gb;
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ga, gb);
  endtask

  initial begin
    logic              ga, gb;
    logic              ap, bpend, bpr;
    logic [4:0]        aar, bar, bar2;
    logic [DATA_W-1:0] adr, bdr, bdr2;

    // Reset with both requesters asserting valid
    model_reset();
    reset_n = 1'b0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'h1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'h2;
    b_pair = 1'b0; b_addr2 = 5'd0; b_data2 = '0;
    repeat (2) @(negedge clk);
    check("rst.a_ready", a_ready, 1'b0);
    check("rst.b_ready", b_ready, 1'b0);
    check_outputs("rst");
    reset_n = 1'b1;

    // Contention after reset: A first, then alternating
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd1, 64'hA0 + 64'(i), 1'b1, 5'd2, 64'hB0 + 64'(i), 1'b0, 5'd0, '0, ga, gb);

    // Single A write, then an idle cycle
    step(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ga, gb);
    check("single.wr_sel", wr_sel, 32'h0000_0020);
    idle_step();

    // Pair while A waits
    step(1'b1, 5'd9, 64'h99, 1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22, ga, gb);
    check("pair.granted_b", b_ready, 1'b0);
    step(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ga, gb);
    step(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ga, gb);

    // XZR: single and as first beat of a pair
    step(1'b1, 5'd31, 64'h3131, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ga, gb);
    step(1'b0, 5'd0, '0, 1'b1, 5'd31, 64'h55, 1'b1, 5'd7, 64'h77, ga, gb);
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ga, gb);
    // Pair with identical addresses
    step(1'b0, 5'd0, '0, 1'b1, 5'd6, 64'h61, 1'b1, 5'd6, 64'h62, ga, gb);
    idle_step();
    idle_step();

    // Reset asserted while the second beat is pending
    step(1'b0, 5'd0, '0, 1'b1, 5'd12, 64'hC1, 1'b1, 5'd13, 64'hC2, ga, gb);
    a_valid = 1'b0; b_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midpair.a_ready", a_ready, 1'b0);
    check_outputs("midpair");
    @(negedge clk);
    reset_n = 1'b1;
    idle_step();
    idle_step();

    // Randomised traffic with hold-until-ready requesters
    ap = 1'b0; bpend = 1'b0;
    aar = '0; adr = '0; bar = '0; bdr = '0; bpr = 1'b0; bar2 = '0; bdr2 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ap && ($urandom_range(0, 2) != 0)) begin
        ap  = 1'b1;
        aar = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
        adr = {$urandom, $urandom};
      end
      if (!bpend && ($urandom_range(0, 2) != 0)) begin
        bpend = 1'b1;
        bar   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
        bdr   = {$urandom, $urandom};
        bpr   = 1'($urandom);
        bar2  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
        bdr2  = {$urandom, $urandom};
      end
      step(ap, aar, adr, bpend, bar, bdr, bpr, bar2, bdr2, ga, gb);
      if (ga) ap = 1'b0;
      if (gb) bpend = 1'b0;
    end
    idle_step();
    idle_step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
